vdc_seg_scan: RTL and testbench

//  Display end of the to_vdc nibble interface driven by the game-control block.
//  - Captures 4-bit to_vdc values into four digit registers, addressed by load[1:0].
//  - Time-multiplexes the four digits onto a common-anode seven-segment display.
//  - Inserts one blanking cycle between digits to suppress ghosting.

---
 rtl/vdc_seg_scan_if.sv | 21 ++
 rtl/vdc_seg_scan.sv | 103 ++++++++++
 tb/tb_vdc_seg_scan.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vdc_seg_scan_if.sv
// Nibble write port from the game-control block plus the multiplexed
// seven-segment display drive it receives back.
interface vdc_seg_scan_if;
  logic [3:0] to_vdc;
  logic [1:0] load;
  logic       wr_en;
  logic [3:0] dp_mask;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output to_vdc, load, wr_en, dp_mask,
    input  an, seg, dp
  );

  modport slave (
    input  to_vdc, load, wr_en, dp_mask,
    output an, seg, dp
  );
endinterface

// File: rtl/vdc_seg_scan.sv
// Four-digit common-anode seven-segment scanner with one blank cycle per slot.
// Optional macro LEAD_ZERO_BLANK_EN blanks leading zero digits 3..1.
module vdc_seg_scan #(
  parameter int          PRESCALE  = 100000,
  parameter logic [3:0]  RESET_NIB = 4'h0
) (
  input  logic           clk,
  input  logic           rst,
  vdc_seg_scan_if.slave  bus
);

  localparam int             PCW     = $clog2(PRESCALE);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PRESCALE - 1);

  logic [PCW-1:0] r_pc;
  logic [1:0]     r_idx;
  logic [3:0]     r_d [4];
  logic [3:0]     r_an;
  logic [6:0]     r_seg;
  logic           r_dp;

  logic           w_blank_slot;
  logic [3:0]     w_nib;
  logic           w_lz;
  logic [3:0]     w_an_nxt;
  logic [6:0]     w_seg_nxt;
  logic           w_dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_blank_slot = (r_pc == PC_LAST);
    w_nib        = r_d[r_idx];
    w_lz         = 1'b0;
    w_an_nxt     = 4'hF;
    w_seg_nxt    = 7'h7F;
    w_dp_nxt     = 1'b1;
`ifdef LEAD_ZERO_BLANK_EN
    case (r_idx)
      2'd3:    w_lz = (r_d[3] == 4'h0);
      2'd2:    w_lz = ((r_d[3] | r_d[2]) == 4'h0);
      2'd1:    w_lz = ((r_d[3] | r_d[2] | r_d[1]) == 4'h0);
      default: w_lz = 1'b0;
    endcase
`endif
    if (!w_blank_slot) begin
      w_an_nxt  = ~(4'b0001 << r_idx);
      w_seg_nxt = w_lz ? 7'h7F : hex7(w_nib);
      w_dp_nxt  = ~bus.dp_mask[r_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc  <= '0;
      r_idx <= 2'd0;
    end else if (w_blank_slot) begin
      r_pc  <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pc  <= r_pc + PCW'(1);
    end
  end

  // NOTE: the four digit registers are flops, not RAM, so resetting them to RESET_NIB is cheap and required.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_d[i] <= RESET_NIB;
    end else if (bus.wr_en) begin
      r_d[bus.load] <= bus.to_vdc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 4'hF;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_vdc_seg_scan.sv
// Self-checking bench for vdc_seg_scan at PRESCALE=4: slot-arithmetic model
// compared every cycle, plus directed literal checks of the scan behaviour.
module tb_vdc_seg_scan;
  localparam int P = 4;

  logic clk;
  logic rst;
  vdc_seg_scan_if bus ();

  vdc_seg_scan #(.PRESCALE(P), .RESET_NIB(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: output after the n-th edge since release depends on
  // slot position (n mod P) and digit ((n div P) mod 4).
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] m_d [4];
  int         m_cnt;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;
  bit         chk_en = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 4'h0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      int  pos, dig;
      bit  lead;
      pos = m_cnt % P;
      dig = (m_cnt / P) % 4;
      if (pos == P - 1) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = 4'hF ^ (4'd1 << dig);
        exp_dp  = ~bus.dp_mask[dig];
        lead    = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        lead = (dig != 0);
        for (int j = dig; j < 4; j++) if (m_d[j] != 4'h0) lead = 1'b0;
`endif
        exp_seg = lead ? 7'h7F : hex_tab[m_d[dig]];
      end
      if (bus.wr_en) m_d[bus.load] = bus.to_vdc;
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_an",  {28'd0, bus.an},  {28'd0, exp_an});
      check("model_seg", {25'd0, bus.seg}, {25'd0, exp_seg});
      check("model_dp",  {31'd0, bus.dp},  {31'd0, exp_dp});
    end
  end

  task automatic write(input logic [1:0] ld, input logic [3:0] val);
    @(negedge clk);
    bus.load   = ld;
    bus.to_vdc = val;
    bus.wr_en  = 1'b1;
    @(negedge clk);
    bus.wr_en  = 1'b0;
  endtask

  task automatic wait_an(input string name, input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.an == target) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  logic [3:0] idle_an [17] = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                               4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE};

  initial begin
    bus.to_vdc  = 4'h0;
    bus.load    = 2'd0;
    bus.wr_en   = 1'b0;
    bus.dp_mask = 4'h0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    check("rst_async_an",  {28'd0, bus.an},  32'hF);
    check("rst_async_seg", {25'd0, bus.seg}, 32'h7F);
    check("rst_async_dp",  {31'd0, bus.dp},  32'd1);
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;

    // Idle scan sequence from the first edge after release.
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      check("idle_an", {28'd0, bus.an}, {28'd0, idle_an[i]});
      if (i == 0) check("first_seg", {25'd0, bus.seg}, 32'h40);
    end

    // Digit 2 <- A.
    write(2'd2, 4'hA);
    wait_an("wait_B", 4'hB);
    check("d2_seg_A", {25'd0, bus.seg}, 32'h08);
    wait_an("wait_D", 4'hD);
    check("d1_seg_0", {25'd0, bus.seg}, 32'h40);

    // Write digit 0 while it is lit; dp on digit 0 only.
    wait_an("wait_F", 4'hF);
    wait_an("wait_E", 4'hE);
    @(negedge clk);
    bus.load    = 2'd0;
    bus.to_vdc  = 4'h5;
    bus.wr_en   = 1'b1;
    bus.dp_mask = 4'b0001;
    @(posedge clk);
    #1;
    check("wr_edge_an",  {28'd0, bus.an},  32'hE);
    check("wr_edge_seg", {25'd0, bus.seg}, 32'h40);
    @(negedge clk);
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("wr_next_an",  {28'd0, bus.an},  32'hE);
    check("wr_next_seg", {25'd0, bus.seg}, 32'h12);
    check("wr_next_dp",  {31'd0, bus.dp},  32'd0);
    wait_an("wait_D2", 4'hD);
    check("d1_dp_off", {31'd0, bus.dp}, 32'd1);

    // Reset mid-slot while digit 2 is lit.
    wait_an("wait_B2", 4'hB);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_an",  {28'd0, bus.an},  32'hF);
    check("mid_rst_seg", {25'd0, bus.seg}, 32'h7F);
    check("mid_rst_dp",  {31'd0, bus.dp},  32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("restart_an",  {28'd0, bus.an},  32'hE);
    check("restart_seg", {25'd0, bus.seg}, 32'h40);

    // Leading-zero pattern d={0,0,0,5}.
    write(2'd0, 4'h5);
    wait_an("wait_7", 4'h7);
`ifdef LEAD_ZERO_BLANK_EN
    check("lz_d3", {25'd0, bus.seg}, 32'h7F);
`else
    check("lz_d3", {25'd0, bus.seg}, 32'h40);
`endif
    wait_an("wait_E2", 4'hE);
    check("lz_d0", {25'd0, bus.seg}, 32'h12);

    // d={0,3,0,0}; back-to-back writes to digit 2, last wins.
    write(2'd0, 4'h0);
    write(2'd2, 4'h7);
    write(2'd2, 4'h3);
    wait_an("wait_7b", 4'h7);
`ifdef LEAD_ZERO_BLANK_EN
    check("lz2_d3", {25'd0, bus.seg}, 32'h7F);
`else
    check("lz2_d3", {25'd0, bus.seg}, 32'h40);
`endif
    wait_an("wait_Eb", 4'hE);
    check("lz2_d0", {25'd0, bus.seg}, 32'h40);
    wait_an("wait_Db", 4'hD);
    check("lz2_d1", {25'd0, bus.seg}, 32'h40);
    wait_an("wait_Bb", 4'hB);
    check("lz2_d2", {25'd0, bus.seg}, 32'h30);

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
